// File: rtl/bus_frame_receiver.sv
// bus_frame_receiver: deframes one 75-bit serial frame from the node bus,
// checks its CRC-4, filters on node address / broadcast mod, and presents
// the accepted payload with one-cycle strobes plus running counters.
module bus_frame_receiver #(
  parameter logic [3:0] MY_ADDR   = 4'd1,
  parameter logic [1:0] BCAST_MOD = 2'b11,
  parameter int         CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bus_in,
  output logic [63:0]      data_out,
  output logic [3:0]       addr_out,
  output logic [1:0]       mod_out,
  output logic             frame_valid,
  output logic             crc_err,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [7:0]       err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_MOD,
    S_DATA,
    S_CRC,
    S_CHECK
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [6:0]       bit_cnt_q, bit_cnt_d;
  logic [69:0]      shift_q, shift_d;
  logic [3:0]       crc_calc_q, crc_calc_d;
  logic [3:0]       crc_rx_q, crc_rx_d;
  logic [63:0]      data_q, data_d;
  logic [3:0]       addr_q, addr_d;
  logic [1:0]       mod_q, mod_d;
  logic             frame_valid_q, frame_valid_d;
  logic             crc_err_q, crc_err_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic             crc_fb;
  logic [3:0]       crc_step;
  logic             addr_match;
  logic             crc_ok;

  // Serial CRC-4 (x^4+x+1) update for the bit currently on the bus, plus
  // the accept decision evaluated against the fully shifted frame.
  always_comb begin
    crc_fb     = crc_calc_q[3] ^ bus_in;
    crc_step   = {crc_calc_q[2], crc_calc_q[1], crc_calc_q[0] ^ crc_fb, crc_fb};
    addr_match = (shift_q[69:66] == MY_ADDR) || (shift_q[65:64] == BCAST_MOD);
    crc_ok     = (crc_calc_q == crc_rx_q);
  end

  // Next-state logic: walks the frame fields, each state reloading the
  // bit counter with its field length minus one, and registers the result.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    crc_calc_d    = crc_calc_q;
    crc_rx_d      = crc_rx_q;
    data_d        = data_q;
    addr_d        = addr_q;
    mod_d         = mod_q;
    frame_valid_d = 1'b0;
    crc_err_d     = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    err_cnt_d     = err_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus_in) begin
          state_d    = S_ADDR;
          bit_cnt_d  = 7'd3;
          crc_calc_d = 4'd0;
          shift_d    = '0;
        end
      end

      S_ADDR, S_MOD, S_DATA: begin
        shift_d    = {shift_q[68:0], bus_in};
        crc_calc_d = crc_step;
        if (bit_cnt_q == 7'd0) begin
          if (state_q == S_ADDR) begin
            state_d   = S_MOD;
            bit_cnt_d = 7'd1;
          end else if (state_q == S_MOD) begin
            state_d   = S_DATA;
            bit_cnt_d = 7'd63;
          end else begin
            state_d   = S_CRC;
            bit_cnt_d = 7'd3;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 7'd1;
        end
      end

      S_CRC: begin
        crc_rx_d = {crc_rx_q[2:0], bus_in};
        if (bit_cnt_q == 7'd0) begin
          state_d   = S_CHECK;
          bit_cnt_d = 7'd0;
        end else begin
          bit_cnt_d = bit_cnt_q - 7'd1;
        end
      end

      S_CHECK: begin
        if (addr_match) begin
          if (crc_ok) begin
            data_d        = shift_q[63:0];
            addr_d        = shift_q[69:66];
            mod_d         = shift_q[65:64];
            frame_valid_d = 1'b1;
            frame_cnt_d   = frame_cnt_q + CNT_ONE;
          end else begin
            crc_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
              err_cnt_d = err_cnt_q + 8'd1;
            end
          end
        end
        if (bus_in) begin
          state_d    = S_ADDR;
          bit_cnt_d  = 7'd3;
          crc_calc_d = 4'd0;
          shift_d    = '0;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      bit_cnt_q     <= 7'd0;
      shift_q       <= '0;
      crc_calc_q    <= 4'd0;
      crc_rx_q      <= 4'd0;
      data_q        <= 64'd0;
      addr_q        <= 4'd0;
      mod_q         <= 2'd0;
      frame_valid_q <= 1'b0;
      crc_err_q     <= 1'b0;
      frame_cnt_q   <= '0;
      err_cnt_q     <= 8'd0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      crc_calc_q    <= crc_calc_d;
      crc_rx_q      <= crc_rx_d;
      data_q        <= data_d;
      addr_q        <= addr_d;
      mod_q         <= mod_d;
      frame_valid_q <= frame_valid_d;
      crc_err_q     <= crc_err_d;
      frame_cnt_q   <= frame_cnt_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign data_out    = data_q;
  assign addr_out    = addr_q;
  assign mod_out     = mod_q;
  assign frame_valid = frame_valid_q;
  assign crc_err     = crc_err_q;
  assign busy        = (state_q != S_IDLE);
  assign frame_cnt   = frame_cnt_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_bus_frame_receiver.sv
// Testbench for bus_frame_receiver: directed frames plus randomized
// traffic compared against a polynomial-division reference model.
module tb_bus_frame_receiver;

  localparam logic [3:0] MY_ADDR = 4'd1;
  localparam logic [1:0] BCAST   = 2'b11;

  logic        clock;
  logic        reset;
  logic        bus_in;
  logic [63:0] data_out;
  logic [3:0]  addr_out;
  logic [1:0]  mod_out;
  logic        frame_valid;
  logic        crc_err;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;

  bus_frame_receiver #(
    .MY_ADDR  (MY_ADDR),
    .BCAST_MOD(BCAST),
    .CNT_W    (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bus_in     (bus_in),
    .data_out   (data_out),
    .addr_out   (addr_out),
    .mod_out    (mod_out),
    .frame_valid(frame_valid),
    .crc_err    (crc_err),
    .busy       (busy),
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt)
  );

  int checks = 0;
  int fails  = 0;

  // Reference model state
  logic [63:0] exp_data;
  logic [3:0]  exp_addr;
  logic [1:0]  exp_mod;
  logic [15:0] exp_fcnt;
  logic [7:0]  exp_ecnt;
  int          exp_fv = 0;
  int          exp_ce = 0;

  // Observed strobe history
  int cyc        = 0;
  int fv_seen    = 0;
  int ce_seen    = 0;
  int both_seen  = 0;
  int fv_times[$];
  int last_start = 0;

  // Free-running 10-unit clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Cycle counter used to time strobes relative to start bits
  always @(posedge clock) cyc <= cyc + 1;

  // Strobe monitor sampling away from the active edge
  always @(negedge clock) begin
    if (frame_valid) begin
      fv_seen <= fv_seen + 1;
      fv_times.push_back(cyc);
    end
    if (crc_err) ce_seen <= ce_seen + 1;
    if (frame_valid && crc_err) both_seen <= both_seen + 1;
  end

  // CRC as the remainder of M(x)*x^4 divided by x^4+x+1
  function automatic logic [3:0] crc_ref(input logic [3:0] a, input logic [1:0] m,
                                         input logic [63:0] d);
    logic [73:0] r;
    r = {a, m, d, 4'b0000};
    for (int i = 73; i >= 4; i--) begin
      if (r[i]) r[i-:5] = r[i-:5] ^ 5'b10011;
    end
    return r[3:0];
  endfunction

  // Model reaction to one complete frame
  task automatic model_frame(input logic [3:0] a, input logic [1:0] m,
                             input logic [63:0] d, input logic [3:0] c);
    if (a == MY_ADDR || m == BCAST) begin
      if (c == crc_ref(a, m, d)) begin
        exp_data = d;
        exp_addr = a;
        exp_mod  = m;
        exp_fcnt = exp_fcnt + 16'd1;
        exp_fv++;
      end else begin
        exp_ce++;
        if (exp_ecnt != 8'hFF) exp_ecnt = exp_ecnt + 8'd1;
      end
    end
  endtask

  task automatic model_reset();
    exp_data = '0;
    exp_addr = '0;
    exp_mod  = '0;
    exp_fcnt = '0;
    exp_ecnt = '0;
  endtask

  // Serialize one frame MSB first, one bit per clock, no trailing gap
  task automatic send_frame(input logic [3:0] a, input logic [1:0] m,
                            input logic [63:0] d, input logic [3:0] c);
    logic [74:0] f;
    f = {1'b1, a, m, d, c};
    for (int i = 0; i < 75; i++) begin
      @(negedge clock);
      if (i == 40) begin
        checks++;
        if (busy !== 1'b1) begin
          fails++;
          $display("[TB] FAIL busy_mid_frame: got %0b expected 1", busy);
        end
      end
      bus_in = f[74-i];
      if (i == 0) last_start = cyc;
    end
    model_frame(a, m, d, c);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      bus_in = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    bus_in = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    checks++;
    if ({data_out, addr_out, mod_out} !== 70'd0) begin
      fails++;
      $display("[TB] FAIL reset_payload: got %0h expected 0", {data_out, addr_out, mod_out});
    end
    checks++;
    if ({frame_valid, crc_err, busy} !== 3'b000) begin
      fails++;
      $display("[TB] FAIL reset_flags: got %b expected 000", {frame_valid, crc_err, busy});
    end
    checks++;
    if ({frame_cnt, err_cnt} !== 24'd0) begin
      fails++;
      $display("[TB] FAIL reset_counters: got %0h expected 0", {frame_cnt, err_cnt});
    end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_accept();
    send_frame(4'd1, 2'b01, 64'h1, 4'b0001);
    idle(3);
    checks++;
    if (fv_seen !== exp_fv || ce_seen !== exp_ce) begin
      fails++;
      $display("[TB] FAIL accept_strobes: got fv=%0d ce=%0d expected fv=%0d ce=%0d",
               fv_seen, ce_seen, exp_fv, exp_ce);
    end
    checks++;
    if ({data_out, addr_out, mod_out} !== {exp_data, exp_addr, exp_mod}) begin
      fails++;
      $display("[TB] FAIL accept_payload: got %0h/%0h/%0h expected %0h/%0h/%0h",
               data_out, addr_out, mod_out, exp_data, exp_addr, exp_mod);
    end
    checks++;
    if (frame_cnt !== exp_fcnt) begin
      fails++;
      $display("[TB] FAIL accept_frame_cnt: got %0d expected %0d", frame_cnt, exp_fcnt);
    end
    // Start bit driven at cycle N; strobe observed 76 clocks later
    checks++;
    if (fv_times.size() == 0 || fv_times[$] - last_start != 76) begin
      fails++;
      $display("[TB] FAIL accept_latency: got %0d expected 76",
               fv_times.size() == 0 ? -1 : fv_times[$] - last_start);
    end
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL idle_busy: got %0b expected 0", busy);
    end
  endtask

  task automatic test_crc_error();
    send_frame(4'd1, 2'b01, 64'h1, 4'b0000);
    idle(3);
    checks++;
    if (fv_seen !== exp_fv || ce_seen !== exp_ce) begin
      fails++;
      $display("[TB] FAIL crcerr_strobes: got fv=%0d ce=%0d expected fv=%0d ce=%0d",
               fv_seen, ce_seen, exp_fv, exp_ce);
    end
    checks++;
    if (err_cnt !== exp_ecnt) begin
      fails++;
      $display("[TB] FAIL crcerr_err_cnt: got %0d expected %0d", err_cnt, exp_ecnt);
    end
    checks++;
    if (data_out !== exp_data || frame_cnt !== exp_fcnt) begin
      fails++;
      $display("[TB] FAIL crcerr_hold: got data=%0h cnt=%0d expected data=%0h cnt=%0d",
               data_out, frame_cnt, exp_data, exp_fcnt);
    end
  endtask

  task automatic test_filter();
    send_frame(4'd2, 2'b00, 64'h0, 4'b1110);
    idle(3);
    checks++;
    if (fv_seen !== exp_fv || ce_seen !== exp_ce || frame_cnt !== exp_fcnt || err_cnt !== exp_ecnt) begin
      fails++;
      $display("[TB] FAIL filter_drop: got fv=%0d ce=%0d fc=%0d ec=%0d expected fv=%0d ce=%0d fc=%0d ec=%0d",
               fv_seen, ce_seen, frame_cnt, err_cnt, exp_fv, exp_ce, exp_fcnt, exp_ecnt);
    end
    send_frame(4'd2, 2'b11, 64'hDEAD_BEEF_0123_4567, crc_ref(4'd2, 2'b11, 64'hDEAD_BEEF_0123_4567));
    idle(3);
    checks++;
    if (fv_seen !== exp_fv || {data_out, addr_out, mod_out} !== {exp_data, exp_addr, exp_mod}) begin
      fails++;
      $display("[TB] FAIL filter_broadcast: got fv=%0d %0h/%0h/%0h expected fv=%0d %0h/%0h/%0h",
               fv_seen, data_out, addr_out, mod_out, exp_fv, exp_data, exp_addr, exp_mod);
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = fv_times.size();
    send_frame(4'd1, 2'b01, 64'h1, 4'b0001);
    send_frame(4'd1, 2'b00, 64'h0, 4'b0111);
    idle(3);
    checks++;
    if (fv_times.size() - n0 != 2 || fv_seen !== exp_fv) begin
      fails++;
      $display("[TB] FAIL b2b_count: got %0d strobes expected 2", fv_times.size() - n0);
    end else begin
      checks++;
      if (fv_times[n0+1] - fv_times[n0] != 75) begin
        fails++;
        $display("[TB] FAIL b2b_spacing: got %0d expected 75", fv_times[n0+1] - fv_times[n0]);
      end
    end
    checks++;
    if (frame_cnt !== exp_fcnt || {data_out, mod_out} !== {exp_data, exp_mod}) begin
      fails++;
      $display("[TB] FAIL b2b_state: got cnt=%0d data=%0h expected cnt=%0d data=%0h",
               frame_cnt, data_out, exp_fcnt, exp_data);
    end
  endtask

  task automatic test_mid_reset();
    logic [74:0] f;
    f = {1'b1, 4'd1, 2'b01, 64'h1, 4'b0001};
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      bus_in = f[74-i];
    end
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({data_out, addr_out, mod_out, frame_valid, crc_err, busy, frame_cnt, err_cnt} !== 97'd0) begin
      fails++;
      $display("[TB] FAIL midreset_outputs: got %0h expected 0",
               {data_out, addr_out, mod_out, frame_valid, crc_err, busy, frame_cnt, err_cnt});
    end
    bus_in = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    idle(2);
    send_frame(4'd1, 2'b01, 64'h1, 4'b0001);
    idle(3);
    checks++;
    if (fv_seen !== exp_fv || frame_cnt !== 16'd1 || data_out !== 64'h1 || err_cnt !== 8'd0) begin
      fails++;
      $display("[TB] FAIL midreset_accept: got fv=%0d cnt=%0d data=%0h ec=%0d expected fv=%0d cnt=1 data=1 ec=0",
               fv_seen, frame_cnt, data_out, err_cnt, exp_fv);
    end
  endtask

  task automatic test_random();
    logic [3:0]  a;
    logic [1:0]  m;
    logic [63:0] d;
    logic [3:0]  c;
    for (int n = 0; n < 40; n++) begin
      a = ($urandom_range(0, 2) == 0) ? MY_ADDR : 4'($urandom_range(0, 15));
      m = 2'($urandom_range(0, 3));
      d = {32'($urandom), 32'($urandom)};
      c = crc_ref(a, m, d);
      if ($urandom_range(0, 3) == 0) c = c ^ 4'($urandom_range(1, 15));
      send_frame(a, m, d, c);
      idle($urandom_range(0, 2));
    end
    idle(3);
    checks++;
    if (fv_seen !== exp_fv || ce_seen !== exp_ce) begin
      fails++;
      $display("[TB] FAIL random_strobes: got fv=%0d ce=%0d expected fv=%0d ce=%0d",
               fv_seen, ce_seen, exp_fv, exp_ce);
    end
    checks++;
    if ({data_out, addr_out, mod_out} !== {exp_data, exp_addr, exp_mod}) begin
      fails++;
      $display("[TB] FAIL random_payload: got %0h/%0h/%0h expected %0h/%0h/%0h",
               data_out, addr_out, mod_out, exp_data, exp_addr, exp_mod);
    end
    checks++;
    if (frame_cnt !== exp_fcnt || err_cnt !== exp_ecnt) begin
      fails++;
      $display("[TB] FAIL random_counters: got fc=%0d ec=%0d expected fc=%0d ec=%0d",
               frame_cnt, err_cnt, exp_fcnt, exp_ecnt);
    end
    checks++;
    if (both_seen !== 0) begin
      fails++;
      $display("[TB] FAIL strobes_exclusive: got %0d overlaps expected 0", both_seen);
    end
  endtask

  task automatic test_err_saturation();
    int guard;
    guard = 0;
    while (exp_ecnt != 8'hFF && guard < 300) begin
      send_frame(4'd1, 2'b01, 64'h1, 4'b0000);
      idle(1);
      guard++;
    end
    idle(3);
    checks++;
    if (err_cnt !== 8'hFF) begin
      fails++;
      $display("[TB] FAIL sat_reach: got %0h expected ff", err_cnt);
    end
    send_frame(4'd1, 2'b01, 64'h1, 4'b0000);
    idle(3);
    checks++;
    if (ce_seen !== exp_ce || err_cnt !== 8'hFF) begin
      fails++;
      $display("[TB] FAIL sat_hold: got ce=%0d ec=%0h expected ce=%0d ec=ff",
               ce_seen, err_cnt, exp_ce);
    end
    checks++;
    if (frame_cnt !== exp_fcnt || fv_seen !== exp_fv) begin
      fails++;
      $display("[TB] FAIL sat_no_accept: got fc=%0d fv=%0d expected fc=%0d fv=%0d",
               frame_cnt, fv_seen, exp_fcnt, exp_fv);
    end
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_accept();
    test_crc_error();
    test_filter();
    test_back_to_back();
    test_mid_reset();
    test_random();
    test_err_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
